// File: rtl/pipe_ex_unit_if.sv
// pipe_ex_unit_if: bundles the execute-stage connections.
//   master: upstream/downstream side. Drives the ID/EX inputs and the WB feedback.
//           Receives the EX results, the hazard controls and the EX/M register outputs.
//   slave : the execute unit itself (pipe_ex_unit).
interface pipe_ex_unit_if;
    // ID stage peek (for early JAL / predicted-branch flush)
    logic [6:0]  id_opcode;
    logic        id_br_pred;
    // ID/EX register contents
    logic [6:0]  ex_opcode;
    logic [3:0]  ex_funct;          // {funct7[5], funct3}
    logic [2:0]  ex_instr_type;
    logic [4:0]  ex_rs1_id, ex_rs2_id, ex_rd_id;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [31:0] ex_pc, ex_rel_target_pc, ex_link_pc;
    logic        ex_br_pred;
    // WB feedback
    logic [4:0]  wb_rd_id;
    logic [6:0]  wb_opcode;
    logic [31:0] wb_wr_data;
    // EX results
    logic [31:0] ex_alu_res, ex_target_pc, ex_redirect_pc;
    logic        br_taken, ex_redirect;
    // hazard control
    logic        pc_stall;
    logic [1:0]  if_id_ctr, id_ex_ctr;
    // WB / M enables
    logic        wb_wr_reg, mem2reg, pc2reg, wr_mem, wr_mem_fwd;
    // EX/M register
    logic [4:0]  m_rd_id, m_rs2_id;
    logic [6:0]  m_opcode;
    logic [2:0]  m_instr_type, m_funct;
    logic [31:0] m_alu_res, m_rs2_data, m_link_pc, m_store_data;

    modport master (
        output id_opcode, id_br_pred, ex_opcode, ex_funct, ex_instr_type,
               ex_rs1_id, ex_rs2_id, ex_rd_id, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_pc, ex_rel_target_pc, ex_link_pc, ex_br_pred,
               wb_rd_id, wb_opcode, wb_wr_data,
        input  ex_alu_res, ex_target_pc, ex_redirect_pc, br_taken, ex_redirect,
               pc_stall, if_id_ctr, id_ex_ctr,
               wb_wr_reg, mem2reg, pc2reg, wr_mem, wr_mem_fwd,
               m_rd_id, m_rs2_id, m_opcode, m_instr_type, m_funct,
               m_alu_res, m_rs2_data, m_link_pc, m_store_data
    );

    modport slave (
        input  id_opcode, id_br_pred, ex_opcode, ex_funct, ex_instr_type,
               ex_rs1_id, ex_rs2_id, ex_rd_id, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_pc, ex_rel_target_pc, ex_link_pc, ex_br_pred,
               wb_rd_id, wb_opcode, wb_wr_data,
        output ex_alu_res, ex_target_pc, ex_redirect_pc, br_taken, ex_redirect,
               pc_stall, if_id_ctr, id_ex_ctr,
               wb_wr_reg, mem2reg, pc2reg, wr_mem, wr_mem_fwd,
               m_rd_id, m_rs2_id, m_opcode, m_instr_type, m_funct,
               m_alu_res, m_rs2_data, m_link_pc, m_store_data
    );
endinterface

// File: rtl/pipe_ex_unit.sv
// pipe_ex_unit: RV32I execute stage.
// It contains the hazard and forwarding controller, the EX datapath
// (forward muxes, operand select, ALU, branch resolve) and the EX/M register.
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset (clears the EX/M register)
//   bus   : pipe_ex_unit_if.slave. It carries the ID/EX inputs and the WB feedback in,
//           and the EX results, stall/flush controls and EX/M outputs out.
// Pipeline control encoding on if_id_ctr/id_ex_ctr: 00 load, 01 hold, 10 flush.
module pipe_ex_unit (
    input  logic           clk,
    input  logic           n_rst,
    pipe_ex_unit_if.slave  bus
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OPI   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    localparam logic [1:0] CTR_LOAD  = 2'b00;
    localparam logic [1:0] CTR_HOLD  = 2'b01;
    localparam logic [1:0] CTR_FLUSH = 2'b10;

    typedef struct packed {
        logic [4:0]  rd_id;
        logic [4:0]  rs2_id;
        logic [6:0]  opcode;
        logic [2:0]  instr_type;
        logic [2:0]  funct;
        logic [31:0] alu_res;
        logic [31:0] rs2_data;
        logic [31:0] link_pc;
    } exm_t;

    exm_t exm_q, exm_d;

    function automatic logic wr_reg(input logic [6:0] op, input logic [4:0] rd);
        return (rd != 5'd0) && (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                           OP_LOAD, OP_OPI, OP_OP});
    endfunction

    // ---------------- forwarding ----------------
    // A load in M has no data yet, so it never forwards; load-use stalls instead.
    logic        m_fwd_ok, wb_fwd_ok;
    logic [31:0] fwd1, fwd2;

    assign m_fwd_ok  = wr_reg(exm_q.opcode, exm_q.rd_id) && (exm_q.opcode != OP_LOAD);
    assign wb_fwd_ok = wr_reg(bus.wb_opcode, bus.wb_rd_id);

    always_comb begin
        fwd1 = bus.ex_rs1_data;
        if (bus.ex_rs1_id != 5'd0 && m_fwd_ok && exm_q.rd_id == bus.ex_rs1_id)
            fwd1 = exm_q.alu_res;
        else if (bus.ex_rs1_id != 5'd0 && wb_fwd_ok && bus.wb_rd_id == bus.ex_rs1_id)
            fwd1 = bus.wb_wr_data;

        fwd2 = bus.ex_rs2_data;
        if (bus.ex_rs2_id != 5'd0 && m_fwd_ok && exm_q.rd_id == bus.ex_rs2_id)
            fwd2 = exm_q.alu_res;
        else if (bus.ex_rs2_id != 5'd0 && wb_fwd_ok && bus.wb_rd_id == bus.ex_rs2_id)
            fwd2 = bus.wb_wr_data;
    end

    // ---------------- ALU ----------------
    logic        is_op, is_opi, is_br, is_jalr;
    logic [31:0] op1, op2, alu;
    logic [4:0]  shamt;
    logic [2:0]  f3;

    assign is_op   = (bus.ex_opcode == OP_OP);
    assign is_opi  = (bus.ex_opcode == OP_OPI);
    assign is_br   = (bus.ex_opcode == OP_BR);
    assign is_jalr = (bus.ex_opcode == OP_JALR);
    assign f3      = bus.ex_funct[2:0];

    always_comb begin
        op1 = fwd1;
        if (bus.ex_opcode == OP_LUI)        op1 = 32'd0;
        else if (bus.ex_opcode == OP_AUIPC) op1 = bus.ex_pc;
        op2 = (is_op || is_br) ? fwd2 : bus.ex_imm;
    end

    assign shamt = op2[4:0];

    always_comb begin
        alu = op1 + op2;
        if (is_op || is_opi) begin
            case (f3)
                3'b000:  alu = (is_op && bus.ex_funct[3]) ? op1 - op2 : op1 + op2;
                3'b001:  alu = op1 << shamt;
                3'b010:  alu = {31'd0, $signed(op1) < $signed(op2)};
                3'b011:  alu = {31'd0, op1 < op2};
                3'b100:  alu = op1 ^ op2;
                3'b101:  alu = bus.ex_funct[3] ? 32'($signed(op1) >>> shamt) : op1 >> shamt;
                3'b110:  alu = op1 | op2;
                default: alu = op1 & op2;
            endcase
        end else if (is_br) begin
            alu = op1 - op2;
        end
    end

    // ---------------- branch resolve ----------------
    logic br_cond;

    always_comb begin
        case (f3)
            3'b000:  br_cond = (fwd1 == fwd2);
            3'b001:  br_cond = (fwd1 != fwd2);
            3'b100:  br_cond = ($signed(fwd1) <  $signed(fwd2));
            3'b101:  br_cond = ($signed(fwd1) >= $signed(fwd2));
            3'b110:  br_cond = (fwd1 <  fwd2);
            3'b111:  br_cond = (fwd1 >= fwd2);
            default: br_cond = 1'b0;
        endcase
    end

    logic        taken;
    logic [31:0] target;

    assign taken  = is_br && br_cond;
    assign target = is_jalr ? (alu & ~32'd1) : bus.ex_rel_target_pc;

    // ---------------- hazards ----------------
    logic uses_rs1, uses_rs2, load_use, redirect;

    assign uses_rs1 = !(bus.ex_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 = is_op || is_br;
    assign load_use = (exm_q.opcode == OP_LOAD) && (exm_q.rd_id != 5'd0) &&
                      ((uses_rs1 && exm_q.rd_id == bus.ex_rs1_id) ||
                       (uses_rs2 && exm_q.rd_id == bus.ex_rs2_id));
    // A stalled branch/JALR may be resolving on stale operands, so it waits.
    assign redirect = (is_jalr || (is_br && taken != bus.ex_br_pred)) && !load_use;

    logic       pc_stall;
    logic [1:0] if_id_ctr, id_ex_ctr;

    always_comb begin
        pc_stall  = 1'b0;
        if_id_ctr = CTR_LOAD;
        id_ex_ctr = CTR_LOAD;
        if (redirect) begin
            if_id_ctr = CTR_FLUSH;
            id_ex_ctr = CTR_FLUSH;
        end else if (load_use) begin
            pc_stall  = 1'b1;
            if_id_ctr = CTR_HOLD;
            id_ex_ctr = CTR_HOLD;
        end else if (bus.id_opcode == OP_JAL ||
                     (bus.id_opcode == OP_BR && bus.id_br_pred)) begin
            if_id_ctr = CTR_FLUSH;
        end
    end

    // ---------------- EX/M register ----------------
    always_comb begin
        exm_d = '0;
        if (!load_use) begin
            exm_d.rd_id      = bus.ex_rd_id;
            exm_d.rs2_id     = bus.ex_rs2_id;
            exm_d.opcode     = bus.ex_opcode;
            exm_d.instr_type = bus.ex_instr_type;
            exm_d.funct      = f3;
            exm_d.alu_res    = alu;
            exm_d.rs2_data   = fwd2;
            exm_d.link_pc    = bus.ex_link_pc;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) exm_q <= '0;
        else        exm_q <= exm_d;
    end

    // ---------------- outputs ----------------
    // Store data from a load that is only now in WB bypasses the EX/M copy.
    logic wr_mem_fwd;
    assign wr_mem_fwd = (exm_q.opcode == OP_STORE) && (bus.wb_opcode == OP_LOAD) &&
                        (exm_q.rs2_id != 5'd0) && (bus.wb_rd_id == exm_q.rs2_id);

    assign bus.ex_alu_res     = alu;
    assign bus.ex_target_pc   = target;
    assign bus.br_taken       = taken;
    assign bus.ex_redirect    = redirect;
    assign bus.ex_redirect_pc = (taken || is_jalr) ? target : bus.ex_link_pc;
    assign bus.pc_stall       = pc_stall;
    assign bus.if_id_ctr      = if_id_ctr;
    assign bus.id_ex_ctr      = id_ex_ctr;
    assign bus.wb_wr_reg      = wb_fwd_ok;
    assign bus.mem2reg        = (bus.wb_opcode == OP_LOAD);
    assign bus.pc2reg         = (bus.wb_opcode == OP_JAL) || (bus.wb_opcode == OP_JALR);
    assign bus.wr_mem         = (exm_q.opcode == OP_STORE);
    assign bus.wr_mem_fwd     = wr_mem_fwd;
    assign bus.m_rd_id        = exm_q.rd_id;
    assign bus.m_rs2_id       = exm_q.rs2_id;
    assign bus.m_opcode       = exm_q.opcode;
    assign bus.m_instr_type   = exm_q.instr_type;
    assign bus.m_funct        = exm_q.funct;
    assign bus.m_alu_res      = exm_q.alu_res;
    assign bus.m_rs2_data     = exm_q.rs2_data;
    assign bus.m_link_pc      = exm_q.link_pc;
    assign bus.m_store_data   = wr_mem_fwd ? bus.wb_wr_data : exm_q.rs2_data;
endmodule

// File: tb/tb_pipe_ex_unit.sv
module tb_pipe_ex_unit;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011;

    localparam int S_ALU = 0, S_TGT = 1, S_TKN = 2, S_RED = 3, S_RPC = 4, S_STL = 5;
    localparam int S_IFID = 6, S_IDEX = 7, S_WBW = 8, S_M2R = 9, S_P2R = 10, S_WRM = 11;
    localparam int S_WMF = 12, S_MOP = 13, S_MSD = 14, S_MALU = 15, S_MRD = 16;
    localparam int S_MTYP = 17, S_MFN = 18;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ex_unit_if bus ();
    pipe_ex_unit dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));

    typedef struct {
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic string sname(input int sel);
        case (sel)
            S_ALU: return "ex_alu_res";   S_TGT: return "ex_target_pc";
            S_TKN: return "br_taken";     S_RED: return "ex_redirect";
            S_RPC: return "ex_redirect_pc"; S_STL: return "pc_stall";
            S_IFID: return "if_id_ctr";   S_IDEX: return "id_ex_ctr";
            S_WBW: return "wb_wr_reg";    S_M2R: return "mem2reg";
            S_P2R: return "pc2reg";       S_WRM: return "wr_mem";
            S_WMF: return "wr_mem_fwd";   S_MOP: return "m_opcode";
            S_MSD: return "m_store_data"; S_MALU: return "m_alu_res";
            S_MRD: return "m_rd_id";      S_MTYP: return "m_instr_type";
            default: return "m_funct";
        endcase
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_ALU: return bus.ex_alu_res;   S_TGT: return bus.ex_target_pc;
            S_TKN: return 32'(bus.br_taken); S_RED: return 32'(bus.ex_redirect);
            S_RPC: return bus.ex_redirect_pc; S_STL: return 32'(bus.pc_stall);
            S_IFID: return 32'(bus.if_id_ctr); S_IDEX: return 32'(bus.id_ex_ctr);
            S_WBW: return 32'(bus.wb_wr_reg); S_M2R: return 32'(bus.mem2reg);
            S_P2R: return 32'(bus.pc2reg);  S_WRM: return 32'(bus.wr_mem);
            S_WMF: return 32'(bus.wr_mem_fwd); S_MOP: return 32'(bus.m_opcode);
            S_MSD: return bus.m_store_data; S_MALU: return bus.m_alu_res;
            S_MRD: return 32'(bus.m_rd_id); S_MTYP: return 32'(bus.m_instr_type);
            default: return 32'(bus.m_funct);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    endtask

    task automatic exp(input int sel, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then retire every queued expectation.
    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(sname(e.sel), obs(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.id_opcode = '0; bus.id_br_pred = 1'b0;
        bus.ex_opcode = '0; bus.ex_funct = '0; bus.ex_instr_type = '0;
        bus.ex_rs1_id = '0; bus.ex_rs2_id = '0; bus.ex_rd_id = '0;
        bus.ex_rs1_data = '0; bus.ex_rs2_data = '0; bus.ex_imm = '0;
        bus.ex_pc = 32'h100; bus.ex_rel_target_pc = 32'h200; bus.ex_link_pc = 32'h104;
        bus.ex_br_pred = 1'b0;
        bus.wb_rd_id = '0; bus.wb_opcode = '0; bus.wb_wr_data = '0;
    endtask

    task automatic set_ex(input logic [6:0] op, input logic [3:0] fn, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm);
        bus.ex_opcode = op; bus.ex_funct = fn;
        bus.ex_rs1_id = rs1; bus.ex_rs2_id = rs2; bus.ex_rd_id = rd;
        bus.ex_rs1_data = d1; bus.ex_rs2_data = d2; bus.ex_imm = imm;
    endtask

    task automatic set_wb(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_opcode = op; bus.wb_rd_id = rd; bus.wb_wr_data = d;
    endtask

    initial begin
        clr();
        // reset state
        #2;
        exp(S_MOP, 0); exp(S_MALU, 0); exp(S_WRM, 0); exp(S_WBW, 0); exp(S_STL, 0);
        drain();
        @(negedge clk); n_rst = 1'b1;
        step();

        // ADDI x1,x0,7 -> M holds x1=7
        set_ex(OPI, 4'b0000, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd7);
        step();
        exp(S_MALU, 7); exp(S_MRD, 1); exp(S_MOP, 32'(OPI)); drain();

        // ADD x3,x1,x2: rs1 from M (7), rs2 from WB (5)
        set_ex(OP, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0);
        set_wb(OP, 5'd2, 32'd5);
        exp(S_ALU, 12); exp(S_TKN, 0); exp(S_RED, 0); exp(S_STL, 0);
        exp(S_IFID, 0); exp(S_IDEX, 0); exp(S_WBW, 1); drain();
        set_ex(OP, 4'b1000, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0);
        exp(S_ALU, 2); drain();
        // rs = x0: register data used as-is
        set_ex(OP, 4'b0000, 5'd0, 5'd0, 5'd3, 32'd3, 32'd4, 32'd0);
        exp(S_ALU, 7); drain();
        set_wb(7'd0, 5'd0, 32'd0);
        set_ex(OP, 4'b0010, 5'd8, 5'd9, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_ALU, 1); drain();
        set_ex(OP, 4'b0011, 5'd8, 5'd9, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_ALU, 0); drain();
        set_ex(OPI, 4'b1101, 5'd8, 5'd0, 5'd3, 32'h8000_0000, 32'd0, 32'd4);
        exp(S_ALU, 32'hF800_0000); drain();
        set_ex(OPI, 4'b0101, 5'd8, 5'd0, 5'd3, 32'h8000_0000, 32'd0, 32'd4);
        exp(S_ALU, 32'h0800_0000); drain();
        set_ex(LUI, 4'b0000, 5'd1, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1234_5000);
        exp(S_ALU, 32'h1234_5000); drain();
        set_ex(AUIPC, 4'b0000, 5'd1, 5'd0, 5'd3, 32'd0, 32'd0, 32'h10);
        exp(S_ALU, 32'h110); drain();

        // load-use: LW x5 into M
        set_ex(LOAD, 4'b0010, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h40);
        step();
        // OPI ignores rs2 even though it names x5
        set_ex(OPI, 4'b0000, 5'd0, 5'd5, 5'd6, 32'd0, 32'd0, 32'd1);
        exp(S_STL, 0); exp(S_IFID, 0); drain();
        set_ex(OP, 4'b0000, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0);
        exp(S_STL, 1); exp(S_IFID, 1); exp(S_IDEX, 1); exp(S_RED, 0); drain();
        step();
        set_wb(LOAD, 5'd5, 32'd9);
        exp(S_MOP, 0); exp(S_ALU, 9); exp(S_STL, 0); exp(S_IFID, 0);
        exp(S_M2R, 1); exp(S_WBW, 1); drain();

        // bubble into M
        clr();
        step();

        // branches
        set_ex(BR, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'd0);
        exp(S_TKN, 1); exp(S_RED, 1); exp(S_RPC, 32'h200); exp(S_TGT, 32'h200);
        exp(S_IFID, 2); exp(S_IDEX, 2); exp(S_STL, 0); drain();
        set_ex(BR, 4'b0001, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'd0);
        exp(S_TKN, 0); exp(S_RED, 0); exp(S_RPC, 32'h104); drain();
        bus.ex_br_pred = 1'b1;
        set_ex(BR, 4'b0100, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_TKN, 1); exp(S_RED, 0); exp(S_IFID, 0); drain();
        set_ex(BR, 4'b0110, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_TKN, 0); exp(S_RED, 1); exp(S_RPC, 32'h104); exp(S_IDEX, 2); drain();
        bus.ex_br_pred = 1'b0;
        set_ex(BR, 4'b0101, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_TKN, 0); exp(S_RED, 0); drain();
        set_ex(BR, 4'b0111, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exp(S_TKN, 1); exp(S_RED, 1); exp(S_RPC, 32'h200); drain();

        // JALR rs1=0x101 imm=4 (ID JAL too: redirect flush wins for id_ex)
        bus.ex_rel_target_pc = 32'h999;
        bus.id_opcode = JAL;
        set_ex(JALR, 4'b0000, 5'd1, 5'd0, 5'd1, 32'h101, 32'd0, 32'd4);
        exp(S_ALU, 32'h105); exp(S_TGT, 32'h104); exp(S_RED, 1); exp(S_RPC, 32'h104);
        exp(S_TKN, 0); exp(S_IDEX, 2); drain();

        // ID-stage flushes with EX bubble
        set_ex(7'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        exp(S_IFID, 2); exp(S_IDEX, 0); exp(S_STL, 0); exp(S_RED, 0); drain();
        bus.id_opcode = BR; bus.id_br_pred = 1'b0;
        exp(S_IFID, 0); drain();
        bus.id_br_pred = 1'b1;
        exp(S_IFID, 2); drain();

        // load-use beats JALR redirect, then resolves from WB
        clr();
        set_ex(LOAD, 4'b0010, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h40);
        step();
        set_ex(JALR, 4'b0000, 5'd5, 5'd0, 5'd1, 32'd0, 32'd0, 32'd4);
        exp(S_RED, 0); exp(S_STL, 1); exp(S_IFID, 1); drain();
        step();
        set_wb(LOAD, 5'd5, 32'h200);
        exp(S_TGT, 32'h204); exp(S_RED, 1); exp(S_STL, 0); drain();

        // store forwarding
        clr();
        set_ex(STORE, 4'b0010, 5'd0, 5'd4, 5'd7, 32'd0, 32'h11, 32'd8);
        bus.ex_instr_type = 3'd5;
        step();
        clr();
        set_wb(LOAD, 5'd4, 32'hAB);
        exp(S_WRM, 1); exp(S_WMF, 1); exp(S_MSD, 32'hAB); exp(S_M2R, 1);
        exp(S_MRD, 7); exp(S_MTYP, 5); exp(S_MFN, 2); drain();
        set_wb(LOAD, 5'd3, 32'hAB);
        exp(S_WMF, 0); exp(S_MSD, 32'h11); drain();
        set_wb(JAL, 5'd1, 32'h104);
        exp(S_P2R, 1); exp(S_WBW, 1); exp(S_M2R, 0); exp(S_WMF, 0); drain();
        set_wb(OP, 5'd0, 32'd1);
        exp(S_WBW, 0); exp(S_P2R, 0); drain();

        // asynchronous reset mid-run, away from the clock edge
        set_wb(7'd0, 5'd0, 32'd0);
        #2;
        n_rst = 1'b0;
        exp(S_MOP, 0); exp(S_MRD, 0); exp(S_MSD, 0); exp(S_WRM, 0);
        exp(S_WBW, 0); exp(S_MTYP, 0); drain();
        @(negedge clk); n_rst = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_ex_unit.md
Name: pipe_ex_unit

Overview:
- Execute-stage slice of the 5-stage RV32I pipeline: hazard/forwarding controller, EX datapath (forward muxes, operand select, ALU, branch resolve) and the EX/M pipeline register.
- Sits between the ID/EX register (its ex_* inputs) and the M stage.
- Drives stall/flush controls for the upstream PC, IF/ID and ID/EX registers, and the WB/M write enables.

Parameters:
- none (RV32I, XLEN 32 fixed)

Ports:
- clk  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
- id_opcode  in  7  opcode in ID
- id_br_pred  in  1  ID predicted branch taken
- ex_opcode  in  7  EX opcode
- ex_funct  in  4  {funct7[5],funct3}
- ex_instr_type  in  3  pass-through tag
- ex_rs1_id, ex_rs2_id, ex_rd_id  in  5 each  register ids
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rel_target_pc, ex_link_pc  in  32 each  ID/EX data (ex_link_pc = pc+4)
- ex_br_pred  in  1  prediction carried with EX instr
- wb_rd_id  in  5; wb_opcode  in  7; wb_wr_data  in  32  WB feedback
- ex_alu_res  out  32; ex_target_pc  out  32; br_taken  out  1
- ex_redirect  out  1; ex_redirect_pc  out  32
- pc_stall  out  1
- if_id_ctr, id_ex_ctr  out  2 each  00 load, 01 hold, 10 flush
- wb_wr_reg, mem2reg, pc2reg, wr_mem, wr_mem_fwd  out  1 each
- m_rd_id, m_rs2_id  out  5; m_opcode  out  7; m_instr_type  out  3; m_funct  out  3
- m_alu_res, m_rs2_data, m_link_pc, m_store_data  out  32

Behaviour:
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LOAD 0000011, STORE 0100011, OPI 0010011, OP 0110011.
- Opcode 0 is a bubble: no write, no redirect.
- "Writes reg" means opcode in {LUI, AUIPC, JAL, JALR, LOAD, OPI, OP} and rd != 0.
- Forwarding, per source rs, with rs != 0:
  - M match with m_opcode writes reg and is not LOAD -> m_alu_res.
  - Else WB match with wb writes reg -> wb_wr_data.
  - Else register data.
  - The forwarded rs2 is what enters EX/M.
- ALU operands:
  - op1 = 0 for LUI, ex_pc for AUIPC, else forwarded rs1.
  - op2 = forwarded rs2 for OP/BR, else ex_imm.
- ALU function:
  - OP/OPI by funct3: ADD/SUB (SUB only for OP with funct[3]), SLL, SLT, SLTU, XOR, SRL/SRA (funct[3]), OR, AND.
  - Shift amount is op2[4:0].
  - BR computes SUB.
  - All other opcodes ADD.
- Branch condition (BR only): funct3 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned. br_taken = 0 for non-BR.
- ex_target_pc = JALR ? (alu_res & ~1) : ex_rel_target_pc.
- ex_redirect = JALR, or BR with br_taken != ex_br_pred. The redirect is suppressed during a load-use stall.
- ex_redirect_pc = br_taken or JALR ? ex_target_pc : ex_link_pc.
- Load-use hazard: m_opcode = LOAD, m_rd_id != 0, and m_rd_id equals
  - ex_rs1_id when EX is not LUI/AUIPC/JAL, or
  - ex_rs2_id when EX is OP/BR.
  - Response: pc_stall = 1, if_id_ctr = 01, id_ex_ctr = 01, EX/M loads a bubble. The WB path forwards next cycle.
- Control priority:
  1. ex_redirect: if_id = id_ex = 10, pc_stall = 0.
  2. Load-use.
  3. ID JAL, or ID BR with id_br_pred: if_id = 10.
  4. Otherwise all 00.
- WB/M controls:
  - wb_wr_reg = WB writes reg; mem2reg = wb_opcode LOAD; pc2reg = wb_opcode JAL/JALR; wr_mem = m_opcode STORE.
  - wr_mem_fwd = STORE in M, LOAD in WB, wb_rd_id == m_rs2_id != 0.
  - m_store_data = wr_mem_fwd ? wb_wr_data : m_rs2_data.
- EX/M register:
  - Async clear on n_rst low: every m_* output = 0.
  - Load on each rising edge; loads all-zero (bubble) on load-use.
  - m_funct = ex_funct[2:0]; m_link_pc = ex_link_pc.
- All non-register outputs are combinational.

Test Plan:
- Reset: n_rst = 0 mid-run -> all m_* = 0 immediately, wr_mem = 0, wb_wr_reg = 0 (WB bubble).
- Forwarding:
  - EX ADD x3,x1,x2 with M ALU rd = x1 (m_alu_res = 7), WB rd = x2 (wb_wr_data = 5), regs 0 -> ex_alu_res = 12.
  - Same pattern with rs = x0 -> no forward.
- Load-use:
  - M LOAD rd = x5; EX ADD x6,x5,x0 -> pc_stall = 1, ctrs 01, next m_opcode = 0.
  - Next cycle, WB LOAD supplies 9 -> alu_res = 9.
- Branches:
  - BEQ with equal operands, ex_br_pred = 0 -> br_taken = 1, redirect = 1, redirect_pc = ex_rel_target_pc, if_id = id_ex = 10.
  - BLT with -1 vs 1, pred = 1 -> no redirect.
  - BLTU same operands, pred = 1 -> redirect to ex_link_pc.
- JALR: rs1 = 0x101, imm = 4 -> ex_target_pc = 0x104, redirect = 1.
- JAL: ID JAL -> if_id = 10.
- Store forwarding: STORE in M with rs2 = x4, WB LOAD rd = x4 data 0xAB -> wr_mem_fwd = 1, m_store_data = 0xAB.
